// File: rtl/fp_addsub_pkg.sv
// Shared modes, operand layout and operand classes for the FP add/sub front end.
package fp_addsub_pkg;

   localparam logic [1:0] MODE_PLUS            = 2'b00;
   localparam logic [1:0] MODE_MINUS           = 2'b01;
   localparam logic [1:0] MODE_REVERSE_MINUS   = 2'b10;
   localparam logic [1:0] MODE_PLUS_THEN_MINUS = 2'b11;

   localparam int unsigned FP_EXP_W = 8;
   localparam int unsigned FP_MAN_W = 23;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] man;
   } fp_t;

   typedef enum logic [1:0] {NORM, ZERO, INF, NAN} fp_class_e;

endpackage

// File: rtl/fp_mag_compare.sv
// Combinational magnitude compare: a_ge_b_o = |A| >= |B|, sign excluded.
module fp_mag_compare
   import fp_addsub_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic [EXP_W-1:0] a_exp_i,
   input  logic [MAN_W-1:0] a_man_i,
   input  logic [EXP_W-1:0] b_exp_i,
   input  logic [MAN_W-1:0] b_man_i,
   output logic             a_ge_b_o
);

   // Exponent-major concatenation orders magnitudes the same way as the exp-then-man test.
   assign a_ge_b_o = {a_exp_i, a_man_i} >= {b_exp_i, b_man_i};

endmodule

// File: rtl/fp_addsub_prep_pipe.sv
// Two-stage FP add/sub front end: classify and compare, then swap, align shift, sign and specials.
module fp_addsub_prep_pipe
   import fp_addsub_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned SH_W  = $clog2(MAN_W + 4)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic                   in_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             out_mode,
   output logic                   out_eff_sub,
   output logic                   out_sign,
   output logic                   out_swap,
   output logic [EXP_W-1:0]       out_exp_big,
   output logic [MAN_W:0]         out_man_big,
   output logic [MAN_W:0]         out_man_small,
   output logic [SH_W-1:0]        out_shift,
   output logic                   out_nan,
   output logic                   out_inf,
   output logic                   out_zero
);

   localparam int unsigned SHIFT_MAX = MAN_W + 3;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } op_t;

   function automatic fp_class_e classify(op_t op);
      if (&op.exp) return (op.man == '0) ? INF : NAN;
      if (op.exp == '0 && op.man == '0) return ZERO;
      return NORM;
   endfunction

   logic s1_valid_q, s2_valid_q, s1_adv, s1_load, s2_load;

   assign s1_adv    = ~s2_valid_q | out_ready;
   assign in_ready  = ~s1_valid_q | s1_adv;
   assign s1_load   = in_valid & in_ready;
   assign s2_load   = s1_valid_q & s1_adv;
   assign out_valid = s2_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         if (in_ready) s1_valid_q <= in_valid;
         if (s1_adv)   s2_valid_q <= s1_valid_q;
      end
   end

   // Stage 1: B carries its effective sign so mode is just the two stored signs.
   op_t       a_in, b_in, s1_a_q, s1_b_q;
   logic      a_ge_b, s1_a_ge_b_q;
   fp_class_e s1_cls_a_q, s1_cls_b_q;

   assign a_in = in_a;
   always_comb begin
      b_in      = in_b;
      b_in.sign = in_b[EXP_W+MAN_W] ^ in_sub;
   end

   fp_mag_compare #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_mag_compare (
      .a_exp_i  (a_in.exp),
      .a_man_i  (a_in.man),
      .b_exp_i  (b_in.exp),
      .b_man_i  (b_in.man),
      .a_ge_b_o (a_ge_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_a_ge_b_q <= 1'b0;
         s1_cls_a_q  <= NORM;
         s1_cls_b_q  <= NORM;
      end else if (s1_load) begin
         s1_a_q      <= a_in;
         s1_b_q      <= b_in;
         s1_a_ge_b_q <= a_ge_b;
         s1_cls_a_q  <= classify(a_in);
         s1_cls_b_q  <= classify(b_in);
      end
   end

   // Stage 2 next-state
   logic             swap_d, eff_sub_d, sign_d, nan_d, inf_d, zero_d, mag_eq;
   logic             a_nan, b_nan, a_inf, b_inf;
   logic [1:0]       mode_d;
   logic [EXP_W-1:0] exp_big_d, exp_small, exp_big_eff, exp_small_eff, diff;
   logic [MAN_W:0]   man_big_d, man_small_d;
   logic [SH_W-1:0]  shift_d;

   always_comb begin
      swap_d        = ~s1_a_ge_b_q;
      mode_d        = {s1_a_q.sign, s1_b_q.sign};
      eff_sub_d     = ^mode_d;
      exp_big_d     = swap_d ? s1_b_q.exp : s1_a_q.exp;
      exp_small     = swap_d ? s1_a_q.exp : s1_b_q.exp;
      man_big_d     = swap_d ? {|s1_b_q.exp, s1_b_q.man} : {|s1_a_q.exp, s1_a_q.man};
      man_small_d   = swap_d ? {|s1_a_q.exp, s1_a_q.man} : {|s1_b_q.exp, s1_b_q.man};
      // Denormals share the scale of exponent 1.
      exp_big_eff   = (exp_big_d == '0) ? EXP_W'(1) : exp_big_d;
      exp_small_eff = (exp_small == '0) ? EXP_W'(1) : exp_small;
      diff          = exp_big_eff - exp_small_eff;
      shift_d       = (32'(diff) > SHIFT_MAX) ? SH_W'(SHIFT_MAX) : SH_W'(diff);
      mag_eq        = (s1_a_q.exp == s1_b_q.exp) && (s1_a_q.man == s1_b_q.man);

      a_nan  = (s1_cls_a_q == NAN);
      b_nan  = (s1_cls_b_q == NAN);
      a_inf  = (s1_cls_a_q == INF);
      b_inf  = (s1_cls_b_q == INF);
      nan_d  = a_nan | b_nan | (a_inf & b_inf & eff_sub_d);
      inf_d  = ~nan_d & (a_inf | b_inf);
      zero_d = (s1_cls_a_q == ZERO) & (s1_cls_b_q == ZERO);

      sign_d = 1'b0;
      case (mode_d)
         MODE_MINUS:           sign_d = swap_d;
         MODE_REVERSE_MINUS:   sign_d = ~swap_d;
         MODE_PLUS_THEN_MINUS: sign_d = 1'b1;
         default:              sign_d = 1'b0;
      endcase
      // Exact cancellation rounds to +0.
      if (eff_sub_d && mag_eq) sign_d = 1'b0;
      if (nan_d)       sign_d = 1'b0;
      else if (inf_d)  sign_d = a_inf ? s1_a_q.sign : s1_b_q.sign;
      else if (zero_d) sign_d = (mode_d == MODE_PLUS_THEN_MINUS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_mode      <= '0;
         out_eff_sub   <= 1'b0;
         out_sign      <= 1'b0;
         out_swap      <= 1'b0;
         out_exp_big   <= '0;
         out_man_big   <= '0;
         out_man_small <= '0;
         out_shift     <= '0;
         out_nan       <= 1'b0;
         out_inf       <= 1'b0;
         out_zero      <= 1'b0;
      end else if (s2_load) begin
         out_mode      <= mode_d;
         out_eff_sub   <= eff_sub_d;
         out_sign      <= sign_d;
         out_swap      <= swap_d;
         out_exp_big   <= exp_big_d;
         out_man_big   <= man_big_d;
         out_man_small <= man_small_d;
         out_shift     <= shift_d;
         out_nan       <= nan_d;
         out_inf       <= inf_d;
         out_zero      <= zero_d;
      end
   end

endmodule
